ysyx_24110015_mem_arbiter: RTL and testbench

//  Two-master to one-slave arbiter in front of the shared SRAM model. Masters: IFU (read-only) and LSU (read/write).

---
 rtl/ysyx_24110015_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_ysyx_24110015_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110015_mem_arbiter.sv
// -----------------------------------------------------------------------------
// ysyx_24110015_mem_arbiter
//
// Two-master (IFU read-only, LSU read/write) to one-slave arbiter sitting in
// front of the shared SRAM model. Requests are serialised onto the SRAM
// level-held ren/wen interface. Responses go back to the owning master over
// valid/ready. ren and wen are decoded from the FSM state, so every
// transaction is followed by at least one cycle with both low (RESP, then
// IDLE). That idle cycle lets the slave delay counter re-arm.
//
// Build option:
//   ARB_TIMEOUT_EN  when defined, adds a BUSY-state watchdog. After
//                   TIMEOUT_CYCLES busy cycles with no slave response, the
//                   transaction completes with resp=2'b10 (SLVERR), rdata=0.
//                   When undefined, no counter is built and BUSY waits forever.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   ifu_valid/addr -> ifu_ready       IFU read request, 1-cycle accept pulse
//   ifu_rsp_valid/rdata/resp          IFU response, held until ifu_rsp_ready
//   lsu_valid/we/addr/wdata/wstrb     LSU request (we=1 write, we=0 read)
//   lsu_ready                         LSU 1-cycle accept pulse
//   lsu_rsp_valid/rdata/resp          LSU response (rdata=0 for writes),
//                                     held until lsu_rsp_ready
//   sram_ren/araddr                   slave read enable (level) and address
//   sram_wen/awaddr/wdata/wstrb       slave write enable (level) and payload
//   sram_rvalid/rdata/rresp           slave read response
//   sram_bvalid/bresp                 slave write response
// -----------------------------------------------------------------------------
module ysyx_24110015_mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   // IFU master
   input  logic                      ifu_valid,
   input  logic [ADDR_WIDTH-1:0]     ifu_addr,
   output logic                      ifu_ready,
   output logic                      ifu_rsp_valid,
   output logic [DATA_WIDTH-1:0]     ifu_rdata,
   output logic [1:0]                ifu_resp,
   input  logic                      ifu_rsp_ready,
   // LSU master
   input  logic                      lsu_valid,
   input  logic                      lsu_we,
   input  logic [ADDR_WIDTH-1:0]     lsu_addr,
   input  logic [DATA_WIDTH-1:0]     lsu_wdata,
   input  logic [DATA_WIDTH/8-1:0]   lsu_wstrb,
   output logic                      lsu_ready,
   output logic                      lsu_rsp_valid,
   output logic [DATA_WIDTH-1:0]     lsu_rdata,
   output logic [1:0]                lsu_resp,
   input  logic                      lsu_rsp_ready,
   // SRAM slave
   output logic                      sram_ren,
   output logic [ADDR_WIDTH-1:0]     sram_araddr,
   output logic                      sram_wen,
   output logic [ADDR_WIDTH-1:0]     sram_awaddr,
   output logic [DATA_WIDTH-1:0]     sram_wdata,
   output logic [DATA_WIDTH/8-1:0]   sram_wstrb,
   input  logic                      sram_rvalid,
   input  logic [DATA_WIDTH-1:0]     sram_rdata,
   input  logic [1:0]                sram_rresp,
   input  logic                      sram_bvalid,
   input  logic [1:0]                sram_bresp
);

   localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic       OWN_IFU     = 1'b0;
   localparam logic       OWN_LSU     = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY_RD = 2'd1,
      ST_BUSY_WR = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic                    owner, owner_nxt;
   logic                    last_grant, last_grant_nxt;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_nxt;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_nxt;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_nxt;
   logic [1:0]              resp_q, resp_nxt;

   logic                    grant_ifu, grant_lsu;
   logic                    busy;
   logic                    own_rsp_ready;
   logic                    tmo_hit;

   assign busy          = (state == ST_BUSY_RD) || (state == ST_BUSY_WR);
   assign own_rsp_ready = (owner == OWN_IFU) ? ifu_rsp_ready : lsu_rsp_ready;

   // Round-robin between the two masters. On a tie, the master that did not
   // win last time is granted. last_grant resets to LSU, so the first tie
   // after reset goes to IFU.
   always_comb begin
      grant_lsu = lsu_valid && (!ifu_valid || (last_grant == OWN_IFU));
      grant_ifu = ifu_valid && !grant_lsu;
   end

`ifdef ARB_TIMEOUT_EN
   localparam int                TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt;

   // Cleared while IDLE, so every BUSY entry starts from zero. It counts one
   // per BUSY cycle. It fires on the cycle it holds TIMEOUT_CYCLES-1, which is
   // the TIMEOUT_CYCLES-th busy cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (state == ST_IDLE) begin
         tmo_cnt <= '0;
      end else if (busy && !tmo_hit) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   assign tmo_hit = busy && (tmo_cnt == TMO_LAST);
`else
   // No watchdog: BUSY waits on the slave indefinitely. TIMEOUT_CYCLES is
   // never negative, so this is a constant 0 that still references the
   // parameter in this build.
   assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

   // Next-state logic and request/response latching.
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_grant_nxt = last_grant;
      addr_nxt       = addr_q;
      wdata_nxt      = wdata_q;
      wstrb_nxt      = wstrb_q;
      rdata_nxt      = rdata_q;
      resp_nxt       = resp_q;

      case (state)
         ST_IDLE: begin
            if (grant_ifu) begin
               owner_nxt      = OWN_IFU;
               last_grant_nxt = OWN_IFU;
               addr_nxt       = ifu_addr;
               wdata_nxt      = '0;
               wstrb_nxt      = '0;
               state_nxt      = ST_BUSY_RD;
            end else if (grant_lsu) begin
               owner_nxt      = OWN_LSU;
               last_grant_nxt = OWN_LSU;
               addr_nxt       = lsu_addr;
               wdata_nxt      = lsu_wdata;
               wstrb_nxt      = lsu_wstrb;
               state_nxt      = lsu_we ? ST_BUSY_WR : ST_BUSY_RD;
            end
         end

         // A slave valid on the same cycle as the watchdog limit takes
         // priority and completes normally.
         ST_BUSY_RD: begin
            if (sram_rvalid) begin
               rdata_nxt = sram_rdata;
               resp_nxt  = sram_rresp;
               state_nxt = ST_RESP;
            end else if (tmo_hit) begin
               rdata_nxt = '0;
               resp_nxt  = RESP_SLVERR;
               state_nxt = ST_RESP;
            end
         end

         ST_BUSY_WR: begin
            if (sram_bvalid) begin
               rdata_nxt = '0;
               resp_nxt  = sram_bresp;
               state_nxt = ST_RESP;
            end else if (tmo_hit) begin
               rdata_nxt = '0;
               resp_nxt  = RESP_SLVERR;
               state_nxt = ST_RESP;
            end
         end

         ST_RESP: begin
            if (own_rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         owner      <= OWN_IFU;
         last_grant <= OWN_LSU;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rdata_q    <= '0;
         resp_q     <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_grant <= last_grant_nxt;
         addr_q     <= addr_nxt;
         wdata_q    <= wdata_nxt;
         wstrb_q    <= wstrb_nxt;
         rdata_q    <= rdata_nxt;
         resp_q     <= resp_nxt;
      end
   end

   // Outputs are decoded from state. The accept pulses come straight from the
   // arbiter, so they are also qualified with rst_n. This keeps every output
   // low while reset is held, even if a master keeps its request up.
   always_comb begin
      ifu_ready     = rst_n && (state == ST_IDLE) && grant_ifu;
      lsu_ready     = rst_n && (state == ST_IDLE) && grant_lsu;

      sram_ren      = (state == ST_BUSY_RD);
      sram_wen      = (state == ST_BUSY_WR);
      sram_araddr   = sram_ren ? addr_q  : '0;
      sram_awaddr   = sram_wen ? addr_q  : '0;
      sram_wdata    = sram_wen ? wdata_q : '0;
      sram_wstrb    = sram_wen ? wstrb_q : '0;

      ifu_rsp_valid = (state == ST_RESP) && (owner == OWN_IFU);
      lsu_rsp_valid = (state == ST_RESP) && (owner == OWN_LSU);
      ifu_rdata     = ifu_rsp_valid ? rdata_q : '0;
      ifu_resp      = ifu_rsp_valid ? resp_q  : '0;
      lsu_rdata     = lsu_rsp_valid ? rdata_q : '0;
      lsu_resp      = lsu_rsp_valid ? resp_q  : '0;
   end

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
`timescale 1ns/1ps
module tb_ysyx_24110015_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           ifu_valid, ifu_ready, ifu_rsp_valid, ifu_rsp_ready;
   logic [AW-1:0]  ifu_addr;
   logic [DW-1:0]  ifu_rdata;
   logic [1:0]     ifu_resp;
   logic           lsu_valid, lsu_we, lsu_ready, lsu_rsp_valid, lsu_rsp_ready;
   logic [AW-1:0]  lsu_addr;
   logic [DW-1:0]  lsu_wdata, lsu_rdata;
   logic [SW-1:0]  lsu_wstrb;
   logic [1:0]     lsu_resp;
   logic           sram_ren, sram_wen, sram_rvalid, sram_bvalid;
   logic [AW-1:0]  sram_araddr, sram_awaddr;
   logic [DW-1:0]  sram_wdata, sram_rdata;
   logic [SW-1:0]  sram_wstrb;
   logic [1:0]     sram_rresp, sram_bresp;

   always #5 clk = ~clk;

   ysyx_24110015_mem_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_valid(ifu_valid), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_resp(ifu_resp),
      .ifu_rsp_ready(ifu_rsp_ready),
      .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_ready(lsu_ready),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_resp(lsu_resp),
      .lsu_rsp_ready(lsu_rsp_ready),
      .sram_ren(sram_ren), .sram_araddr(sram_araddr),
      .sram_wen(sram_wen), .sram_awaddr(sram_awaddr),
      .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb),
      .sram_rvalid(sram_rvalid), .sram_rdata(sram_rdata), .sram_rresp(sram_rresp),
      .sram_bvalid(sram_bvalid), .sram_bresp(sram_bresp)
   );

   // ---------------- SRAM slave model: 5-cycle delay ----------------
   // Responds once ren/wen has been seen high on 5 edges (pulse on the 6th
   // busy cycle), then waits for ren/wen to drop before re-arming.
   logic [31:0] mem [logic [31:0]];
   logic [2:0]  sl_cnt;
   logic        sl_done;
   logic        slave_mute = 1'b0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      case (a)
         32'h8000_0000: return 32'hDEAD_BEEF;
         32'h8000_0004: return 32'hCAFE_F00D;
         default:       return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_d, input logic [31:0] new_d,
                                         input logic [3:0] st);
      logic [31:0] r;
      r = old_d;
      for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sl_cnt <= '0; sl_done <= 1'b0;
         sram_rvalid <= 1'b0; sram_bvalid <= 1'b0;
         sram_rdata <= '0; sram_rresp <= '0; sram_bresp <= '0;
      end else begin
         sram_rvalid <= 1'b0;
         sram_bvalid <= 1'b0;
         if (!sram_ren && !sram_wen) begin
            sl_cnt <= '0; sl_done <= 1'b0;
         end else if (!sl_done && !slave_mute) begin
            if (sl_cnt == 3'd4) begin
               sl_done <= 1'b1;
               if (sram_ren) begin
                  sram_rvalid <= 1'b1;
                  sram_rdata  <= mem_rd(sram_araddr);
                  sram_rresp  <= 2'b00;
               end else begin
                  sram_bvalid <= 1'b1;
                  sram_bresp  <= 2'b00;
                  mem[sram_awaddr] = merge(mem_rd(sram_awaddr), sram_wdata, sram_wstrb);
               end
            end else begin
               sl_cnt <= sl_cnt + 3'd1;
            end
         end
      end
   end

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [33:0] ifu_q[$];
   logic [33:0] lsu_q[$];
   int          grant_log[$];
   int          ren_cycles = 0, wen_cycles = 0, act_edges = 0;
   logic        prev_act = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expected responses on each response handshake.
   initial begin
      logic [33:0] e;
      forever begin
         @(negedge clk);
         check("protocol", {61'd0, sram_ren & sram_wen, ifu_rsp_valid & lsu_rsp_valid,
                            ifu_ready & lsu_ready}, 64'd0);
         if (ifu_ready) grant_log.push_back(0);
         if (lsu_ready) grant_log.push_back(1);
         if (sram_ren) ren_cycles++;
         if (sram_wen) wen_cycles++;
         if ((sram_ren || sram_wen) && !prev_act) act_edges++;
         prev_act = sram_ren || sram_wen;
         if (ifu_rsp_valid && ifu_rsp_ready) begin
            if (ifu_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL ifu_unexpected_rsp: got rdata %0h resp %0h, none expected", ifu_rdata, ifu_resp);
            end else begin
               e = ifu_q.pop_front();
               check("ifu_rsp", {30'd0, ifu_rdata, ifu_resp}, {30'd0, e});
            end
         end
         if (lsu_rsp_valid && lsu_rsp_ready) begin
            if (lsu_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL lsu_unexpected_rsp: got rdata %0h resp %0h, none expected", lsu_rdata, lsu_resp);
            end else begin
               e = lsu_q.pop_front();
               check("lsu_rsp", {30'd0, lsu_rdata, lsu_resp}, {30'd0, e});
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_ready(input bit is_lsu, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (is_lsu ? lsu_ready : ifu_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL wait_ready: got no accept from %s, required one within 60 cycles",
                  is_lsu ? "lsu" : "ifu");
      end
   endtask

   task automatic drain(input int maxc);
      int n;
      n = 0;
      while ((ifu_q.size() != 0 || lsu_q.size() != 0) && n < maxc) begin step(); n++; end
      check("drain_pending", 64'(ifu_q.size() + lsu_q.size()), 64'd0);
   endtask

   task automatic ifu_op(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
      bit ok;
      ifu_q.push_back({exp_d, exp_r});
      ifu_addr = a; ifu_valid = 1'b1;
      wait_ready(1'b0, ok);
      step(); ifu_valid = 1'b0;
   endtask

   task automatic lsu_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic [31:0] exp_d);
      bit ok;
      lsu_q.push_back({exp_d, 2'b00});
      lsu_we = we; lsu_addr = a; lsu_wdata = wd; lsu_wstrb = st; lsu_valid = 1'b1;
      wait_ready(1'b1, ok);
      step(); lsu_valid = 1'b0;
   endtask

   function automatic logic any_out();
      return |{ifu_ready, ifu_rsp_valid, ifu_rdata, ifu_resp, lsu_ready, lsu_rsp_valid,
               lsu_rdata, lsu_resp, sram_ren, sram_araddr, sram_wen, sram_awaddr,
               sram_wdata, sram_wstrb};
   endfunction

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, required finish before 200us");
      $fatal(1);
   end

   // ---------------- directed tests ----------------
   initial begin
      bit ok;
      int r0, w0, g0, e0, ic, lc;
      rst_n = 1'b0;
      ifu_valid = 0; ifu_addr = '0; ifu_rsp_ready = 1;
      lsu_valid = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0; lsu_rsp_ready = 1;
      repeat (3) step();
      check("reset_outputs", 64'(any_out()), 64'd0);
      rst_n = 1'b1;
      step();

      // 1: single IFU read
      r0 = ren_cycles; w0 = wen_cycles; g0 = grant_log.size();
      ifu_q.push_back({32'hDEAD_BEEF, 2'b00});
      ifu_addr = 32'h8000_0000; ifu_valid = 1'b1;
      wait_ready(1'b0, ok);
      check("t1_lsu_ready", 64'(lsu_ready), 64'd0);
      step();
      @(negedge clk);
      check("t1_ready_pulse", 64'(ifu_ready), 64'd0);
      check("t1_ren_addr", {31'd0, sram_ren, sram_araddr}, {31'd0, 1'b1, 32'h8000_0000});
      check("t1_wen", 64'(sram_wen), 64'd0);
      @(posedge clk); #1; ifu_valid = 1'b0;
      drain(50);
      check("t1_ren_cycles", 64'(ren_cycles - r0), 64'd6);
      check("t1_wen_cycles", 64'(wen_cycles - w0), 64'd0);
      check("t1_grants", 64'(grant_log.size() - g0), 64'd1);

      // 2: LSU full write, readback, partial write, readback
      r0 = ren_cycles; w0 = wen_cycles;
      lsu_q.push_back({32'h0, 2'b00});
      lsu_we = 1; lsu_addr = 32'h8000_0010; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hF;
      lsu_valid = 1'b1;
      wait_ready(1'b1, ok);
      step(); lsu_valid = 1'b0;
      @(negedge clk);
      check("t2_wen_addr", {31'd0, sram_wen, sram_awaddr}, {31'd0, 1'b1, 32'h8000_0010});
      check("t2_wdata_strb", {28'd0, sram_wstrb, sram_wdata}, {28'd0, 4'hF, 32'h1234_5678});
      @(posedge clk); #1;
      drain(50);
      check("t2_ren_cycles", 64'(ren_cycles - r0), 64'd0);
      check("t2_wen_cycles", 64'(wen_cycles - w0), 64'd6);
      lsu_op(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'h1234_5678);
      drain(50);
      lsu_op(1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'h5, 32'h0);
      drain(50);
      lsu_op(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'h12BB_56DD);
      drain(50);

      // 3: both masters requesting continuously out of reset
      rst_n = 1'b0;
      ifu_addr = 32'h8000_0000; ifu_valid = 1'b1;
      lsu_we = 1'b0; lsu_addr = 32'h8000_0004; lsu_valid = 1'b1;
      @(negedge clk);
      check("t3_ready_in_reset", {62'd0, ifu_ready, lsu_ready}, 64'd0);
      step();
      rst_n = 1'b1;
      g0 = grant_log.size(); e0 = act_edges;
      ifu_q.push_back({32'hDEAD_BEEF, 2'b00}); ifu_q.push_back({32'hDEAD_BEEF, 2'b00});
      lsu_q.push_back({32'hCAFE_F00D, 2'b00}); lsu_q.push_back({32'hCAFE_F00D, 2'b00});
      ic = 0; lc = 0;
      for (int i = 0; i < 200 && (ifu_valid || lsu_valid); i++) begin
         @(negedge clk);
         if (ifu_ready) ic++;
         if (lsu_ready) lc++;
         @(posedge clk); #1;
         if (ic == 2) ifu_valid = 1'b0;
         if (lc == 2) lsu_valid = 1'b0;
      end
      ifu_valid = 1'b0; lsu_valid = 1'b0;
      drain(60);
      check("t3_grant_count", 64'(grant_log.size() - g0), 64'd4);
      for (int k = 0; k < 4; k++)
         check("t3_grant_order", 64'((g0 + k < grant_log.size()) ? grant_log[g0 + k] : 7),
               64'(k % 2));
      check("t3_idle_gaps", 64'(act_edges - e0), 64'd4);

      // 4: LSU holds off its response; IFU requests meanwhile
      lsu_rsp_ready = 1'b0;
      lsu_op(1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = lsu_rsp_valid;
      end
      check("t4_rsp_seen", 64'(ok), 64'd1);
      step();
      ifu_q.push_back({32'hCAFE_F00D, 2'b00});
      ifu_addr = 32'h8000_0004; ifu_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t4_hold", {27'd0, lsu_rsp_valid, lsu_rdata, lsu_resp, ifu_ready,
                           sram_ren, sram_wen, ifu_rsp_valid},
               {27'd0, 1'b1, 32'hDEAD_BEEF, 2'b00, 4'b0000});
         @(posedge clk); #1;
      end
      lsu_rsp_ready = 1'b1;
      wait_ready(1'b0, ok);
      step(); ifu_valid = 1'b0;
      drain(50);

      // 5: reset during BUSY_RD aborts the read; no response is delivered
      ifu_addr = 32'h8000_0004; ifu_valid = 1'b1;
      wait_ready(1'b0, ok);
      step();
      @(negedge clk);
      check("t5_busy_rd", 64'(sram_ren), 64'd1);
      #2; rst_n = 1'b0; #1;
      check("t5_reset_outputs", 64'(any_out()), 64'd0);
      step();
      ifu_valid = 1'b0; rst_n = 1'b1;
      step();
      ifu_op(32'h8000_0004, 32'hCAFE_F00D, 2'b00);
      drain(50);

      // 6: slave never responds
      slave_mute = 1'b1;
`ifdef ARB_TIMEOUT_EN
      r0 = ren_cycles;
      ifu_op(32'h8000_0008, 32'h0, 2'b10);
      drain(100);
      check("t6_busy_cycles", 64'(ren_cycles - r0), 64'(TMO));
`else
      ifu_addr = 32'h8000_0008; ifu_valid = 1'b1;
      wait_ready(1'b0, ok);
      step(); ifu_valid = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      check("t6_still_busy", {62'd0, sram_ren, ifu_rsp_valid}, {62'd0, 2'b10});
      @(posedge clk); #1;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
`endif
      slave_mute = 1'b0;
      step();
      check("final_queues", 64'(ifu_q.size() + lsu_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
